// File: rtl/sync_deglitch.sv
// sync_deglitch: glitch filter for an already-synchronized level.
// DOUT follows DIN only after FILTER_CYCLES consecutive samples that differ
// from it. The block emits one-cycle RISE/FALL/GLITCH strobes and keeps a
// saturating count of qualified rising edges. It adds no CDC stages.
module sync_deglitch #(
    parameter logic INIT          = 1'b0,
    parameter int   FILTER_CYCLES = 4,
    parameter int   CNT_WIDTH     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 DIN,
    input  logic                 EVT_CLR,
    output logic                 DOUT,
    output logic                 RISE,
    output logic                 FALL,
    output logic                 GLITCH,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] EVT_CNT
);

    // Wide enough to hold FILTER_CYCLES itself, and never narrower than one bit.
    localparam int QW = $clog2(FILTER_CYCLES + 1);
    localparam logic [QW-1:0] QUAL_LAST = QW'(FILTER_CYCLES - 1);

    // Reject illegal parameter values while the design is being elaborated.
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255 || CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_param
        $fatal(1, "Attribute Syntax Error: FILTER_CYCLES must be 1..255 and CNT_WIDTH 1..32");
    end

    typedef enum logic {
        STABLE = 1'b0,
        QUAL   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [QW-1:0]        qual_cnt_q, qual_cnt_d;
    logic                 dout_q, dout_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 glitch_q, glitch_d;
    logic [CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
    logic                 differs;

    // Saturating increment: an all-ones count stays where it is.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Next-state logic: qualification FSM, strobes and event counter.
    always_comb begin
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        dout_d     = dout_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_d   = 1'b0;
        differs    = (DIN != dout_q);

        case (state_q)
            STABLE: begin
                if (differs) begin
                    if (FILTER_CYCLES == 1) begin
                        // A single differing sample is enough, so DOUT flips on this edge.
                        dout_d = ~dout_q;
                        rise_d = ~dout_q;
                        fall_d = dout_q;
                    end else begin
                        state_d    = QUAL;
                        qual_cnt_d = QW'(1);
                    end
                end
            end
            QUAL: begin
                if (!differs) begin
                    // DIN fell back before qualifying, so this pulse is rejected.
                    state_d    = STABLE;
                    qual_cnt_d = '0;
                    glitch_d   = 1'b1;
                end else if (qual_cnt_q == QUAL_LAST) begin
                    dout_d     = ~dout_q;
                    rise_d     = ~dout_q;
                    fall_d     = dout_q;
                    state_d    = STABLE;
                    qual_cnt_d = '0;
                end else begin
                    qual_cnt_d = qual_cnt_q + QW'(1);
                end
            end
            default: begin
                state_d    = STABLE;
                qual_cnt_d = '0;
            end
        endcase

        // A clear that coincides with a rise still counts that rise.
        if (EVT_CLR) begin
            evt_cnt_d = rise_d ? CNT_WIDTH'(1) : '0;
        end else if (rise_d) begin
            evt_cnt_d = sat_inc(evt_cnt_q);
        end else begin
            evt_cnt_d = evt_cnt_q;
        end
    end

    // State and output registers; reset overrides everything and aborts qualification silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= STABLE;
            qual_cnt_q <= '0;
            dout_q     <= INIT;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            glitch_q   <= 1'b0;
            evt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            qual_cnt_q <= qual_cnt_d;
            dout_q     <= dout_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            glitch_q   <= glitch_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign DOUT    = dout_q;
    assign RISE    = rise_q;
    assign FALL    = fall_q;
    assign GLITCH  = glitch_q;
    assign BUSY    = (state_q == QUAL);
    assign EVT_CNT = evt_cnt_q;

endmodule
